mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle CPU control unit: decodes OP/func, sequences IF/ID/EXE/MEM/WB and drives datapath control.
//  Adds over the previous generation: ack-handshaked instruction/data memory with wait-state timeout,
//  precise overflow trap to an exception vector, resumable HALT and a latched exception cause.
//  Sits between IR/ALU flags and the datapath (PC, regfile, ALU, data memory) of the multi-cycle CPU.
// PARAMETERS
//  TMO_W       4  width of wait-state counter; timeout after 2**TMO_W-1 cycles without ack
//  OVF_TRAP    1  1: add/sub overflow in EXEa traps to EXC; 0: result written anyway
//  HALT_RESUME 1  1: resume pulse leaves HLT; 0: HLT is terminal until RST
// PORTS
//  CLK        in   1  clock, rising edge
//  RST        in   1  asynchronous reset, active-high
//  OP         in   6  opcode from IR
//  func       in   6  function field from IR (Rtype)
//  zero,sign  in   1  ALU flags (valid in EXEb)
//  overflow   in   1  ALU signed overflow (valid in EXEa)
//  i_ack      in   1  instruction memory data valid
//  d_ack      in   1  data memory read data valid / write accepted
//  resume     in   1  leave HLT (single-cycle pulse)
//  PCWre,IRWre,RegWre,ALUSrcA,ALUSrcB,DBDataSrc,ExtSel,mRD,mWR  out 1  datapath controls (meaning as in existing CPU)
//  ALUOp out 3; RegDst out 2; PCSrc out 2 (00 +4, 01 branch, 10 exc vector, 11 jump)
//  state      out  4  current state (encoding below)
//  HALT       out  1  high while in HLT
//  exc        out  1  one-cycle pulse in EXC
//  exc_cause  out  2  latched: 00 none, 01 overflow, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  Reset (async): state=IF(0000), wait cnt=0, exc_cause=00; all outputs 0 except ExtSel per decode; IRWre then follows i_ack.
//  Encoding: IF 0000, ID 0001, EXEa 0110, EXEb 0101, EXEls 0010, MEM 0011, WBa 0111, WBm 0100, HLT 1000, EXC 1001.
//  IF: IRWre=i_ack; i_ack -> ID. No ack for 2**TMO_W-1 cycles -> EXC, cause 10.
//  ID: beq/bne/bltz->EXEb; lw/sw->EXEls; j->IF (PCWre=1,PCSrc=11); halt->HLT; else->EXEa. Undefined OP treated as EXEa.
//  EXEa: overflow&&OVF_TRAP&&(add|sub) -> EXC cause 01 (no RegWre ever issued); else ->WBa.
//  EXEb: PCWre=1, PCSrc=01 if taken (beq&zero, bne&!zero, bltz&sign) else 00; ->IF.
//  EXEls: ->MEM. MEM: mRD=lw, mWR=sw held every cycle until d_ack; on d_ack lw->WBm, sw->IF with PCWre=1.
//   No d_ack within 2**TMO_W-1 cycles -> EXC cause 11; mRD/mWR drop on exit.
//  WBa/WBm: RegWre=1, PCWre=1, ->IF. DBDataSrc=1 only for lw.
//  HLT: HALT=1, PCWre=0; resume&&HALT_RESUME -> IF with PCWre=1 (PC+4, past halt).
//  EXC: exc=1, PCWre=1, PCSrc=10, exc_cause loaded that cycle (held until next EXC or RST); ->IF.
//  Wait counter: clears on every state change, increments while in IF/MEM without ack, saturates; ack on timeout cycle wins.
//  Combinational decode (ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst) identical to current CPU table; outputs gated by state as above.
//  PCWre asserted exactly once per instruction; RST mid-instruction aborts with no further RegWre/mWR.
// TESTING
//  addu $3,$1,$2 with i_ack=1 always -> IF,ID,EXEa,WBa; RegWre=1 only in WBa; 4 cycles/instr.
//  lw with d_ack delayed 3 cycles -> mRD high 4 MEM cycles, then WBm with RegWre=1, DBDataSrc=1.
//  add with overflow=1 in EXEa, OVF_TRAP=1 -> EXC next cycle, PCSrc=10, exc pulse, exc_cause=01, no RegWre.
//  sw with d_ack never, TMO_W=4 -> 15 MEM cycles then EXC, exc_cause=11, mWR low after.
//  halt then resume pulse 5 cycles later -> HALT=1 for 5 cycles, then IF with PCWre=1 PCSrc=00.
//  RST asserted during MEM of sw -> state=0000 immediately, mWR=0 asynchronously, exc_cause=00.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle CPU control FSM with ack handshakes, timeouts, overflow trap and resumable halt
//
// Decodes OP/func and sequences IF/ID/EXE/MEM/WB, driving PC, regfile, ALU and
// data-memory controls. Memory phases wait on i_ack/d_ack; a stalled access
// traps to the exception vector after 2**TMO_W-1 cycles.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   OP, func            opcode and R-type function field from IR
//   zero, sign          ALU flags, sampled in EXEb
//   overflow            ALU signed overflow, sampled in EXEa
//   i_ack, d_ack        instruction / data memory handshakes
//   resume              pulse that leaves HLT
//   PCWre..mWR          datapath strobes and selects
//   ALUOp, RegDst       ALU operation, register destination select
//   PCSrc               00 +4, 01 branch, 10 exception vector, 11 jump
//   state, HALT, exc    current state, halted flag, exception pulse
//   exc_cause           00 none, 01 overflow, 10 imem timeout, 11 dmem timeout
module mc_ctrl_fsm #(
    parameter int TMO_W       = 4,
    parameter bit OVF_TRAP    = 1'b1,
    parameter bit HALT_RESUME = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OP,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       sign,
    input  logic       overflow,
    input  logic       i_ack,
    input  logic       d_ack,
    input  logic       resume,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       HALT,
    output logic       exc,
    output logic [1:0] exc_cause
);

    localparam logic [3:0] S_IF    = 4'b0000;
    localparam logic [3:0] S_ID    = 4'b0001;
    localparam logic [3:0] S_EXELS = 4'b0010;
    localparam logic [3:0] S_MEM   = 4'b0011;
    localparam logic [3:0] S_WBM   = 4'b0100;
    localparam logic [3:0] S_EXEB  = 4'b0101;
    localparam logic [3:0] S_EXEA  = 4'b0110;
    localparam logic [3:0] S_WBA   = 4'b0111;
    localparam logic [3:0] S_HLT   = 4'b1000;
    localparam logic [3:0] S_EXC   = 4'b1001;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2a;

    // The current wait cycle is the (2**TMO_W-1)th once the counter shows one less.
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;
    localparam logic [TMO_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

    logic [3:0]       state_n;
    logic [1:0]       cause_n;
    logic [TMO_W-1:0] wait_cnt;
    logic             timeout;

    logic is_lw, is_sw, is_j, is_halt, is_branch, is_add_sub, taken;
    logic dec_srca, dec_srcb, dec_ext, dp_active;
    logic [2:0] dec_aluop;
    logic [1:0] dec_regdst;

    assign is_lw      = (OP == OP_LW);
    assign is_sw      = (OP == OP_SW);
    assign is_j       = (OP == OP_J);
    assign is_halt    = (OP == OP_HALT);
    assign is_branch  = (OP == OP_BEQ) || (OP == OP_BNE) || (OP == OP_BLTZ);
    assign is_add_sub = (OP == OP_R) && ((func == F_ADD) || (func == F_SUB));
    assign taken      = ((OP == OP_BEQ) && zero) || ((OP == OP_BNE) && !zero) ||
                        ((OP == OP_BLTZ) && sign);
    assign timeout    = (wait_cnt == CNT_LAST);

    // Instruction decode table.
    always_comb begin
        dec_srca   = 1'b0;
        dec_srcb   = 1'b0;
        dec_ext    = 1'b0;
        dec_aluop  = 3'b000;
        dec_regdst = 2'b00;
        case (OP)
            OP_R: begin
                dec_regdst = 2'b01;
                case (func)
                    F_SUB, F_SUBU: dec_aluop = 3'b001;
                    F_AND:         dec_aluop = 3'b100;
                    F_OR:          dec_aluop = 3'b011;
                    F_SLT:         dec_aluop = 3'b101;
                    F_SLL: begin
                        dec_aluop = 3'b010;
                        dec_srca  = 1'b1;
                    end
                    default:       dec_aluop = 3'b000;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                dec_srcb = 1'b1;
                dec_ext  = 1'b1;
            end
            OP_SLTI: begin
                dec_srcb  = 1'b1;
                dec_ext   = 1'b1;
                dec_aluop = 3'b101;
            end
            OP_ANDI: begin
                dec_srcb  = 1'b1;
                dec_aluop = 3'b100;
            end
            OP_ORI: begin
                dec_srcb  = 1'b1;
                dec_aluop = 3'b011;
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                dec_ext   = 1'b1;
                dec_aluop = 3'b001;
            end
            default: ;
        endcase
    end

    // Decode-driven selects are quiet outside the instruction body.
    assign dp_active = (state != S_IF) && (state != S_HLT) && (state != S_EXC);
    assign ALUSrcA   = dp_active && dec_srca;
    assign ALUSrcB   = dp_active && dec_srcb;
    assign ALUOp     = dp_active ? dec_aluop : 3'b000;
    assign RegDst    = dp_active ? dec_regdst : 2'b00;
    assign ExtSel    = dec_ext;

    always_comb begin
        state_n = state;
        cause_n = exc_cause;
        case (state)
            S_IF: begin
                if (i_ack) begin
                    state_n = S_ID;
                end else if (timeout) begin
                    state_n = S_EXC;
                    cause_n = 2'b10;
                end
            end
            S_ID: begin
                if (is_branch)           state_n = S_EXEB;
                else if (is_lw || is_sw) state_n = S_EXELS;
                else if (is_j)           state_n = S_IF;
                else if (is_halt)        state_n = S_HLT;
                else                     state_n = S_EXEA;
            end
            S_EXEA: begin
                if (OVF_TRAP && overflow && is_add_sub) begin
                    state_n = S_EXC;
                    cause_n = 2'b01;
                end else begin
                    state_n = S_WBA;
                end
            end
            S_EXELS: state_n = S_MEM;
            S_MEM: begin
                if (d_ack) begin
                    state_n = is_lw ? S_WBM : S_IF;
                end else if (timeout) begin
                    state_n = S_EXC;
                    cause_n = 2'b11;
                end
            end
            S_HLT: begin
                if (HALT_RESUME && resume) state_n = S_IF;
            end
            default: state_n = S_IF;
        endcase
    end

    // exc_cause is loaded on entry to EXC so it is already valid during the exc pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IF;
            wait_cnt  <= '0;
            exc_cause <= 2'b00;
        end else begin
            state     <= state_n;
            exc_cause <= cause_n;
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (((state == S_IF) || (state == S_MEM)) && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        HALT      = 1'b0;
        exc       = 1'b0;
        case (state)
            S_IF: IRWre = i_ack;
            S_ID: begin
                if (is_j) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b11;
                end
            end
            S_EXEB: begin
                PCWre = 1'b1;
                if (taken) PCSrc = 2'b01;
            end
            S_MEM: begin
                mRD   = is_lw;
                mWR   = is_sw;
                PCWre = d_ack && is_sw;
            end
            S_WBA: begin
                RegWre = 1'b1;
                PCWre  = 1'b1;
            end
            S_WBM: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                DBDataSrc = 1'b1;
            end
            S_HLT: begin
                HALT  = 1'b1;
                PCWre = resume && HALT_RESUME;
            end
            S_EXC: begin
                exc   = 1'b1;
                PCWre = 1'b1;
                PCSrc = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    localparam int TMO = 15;

    localparam logic [3:0] ST_IF = 4'h0, ST_ID = 4'h1, ST_EXELS = 4'h2, ST_MEM = 4'h3,
                           ST_WBM = 4'h4, ST_EXEB = 4'h5, ST_EXEA = 4'h6, ST_WBA = 4'h7,
                           ST_HLT = 4'h8, ST_EXC = 4'h9;

    localparam logic [5:0] OP_R = 6'h00, OP_BLTZ = 6'h01, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                           OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LW = 6'h23, OP_SW = 6'h2b,
                           OP_HALT = 6'h3f, OP_UNDEF = 6'h33;
    localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                           F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;

    localparam int C_ALU = 0, C_AS = 1, C_BR = 2, C_LW = 3, C_SW = 4, C_J = 5, C_HLT = 6;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         i_wait;
        int         d_wait;
        int         h_wait;
        logic       z;
        logic       s;
        logic       ovf;
    } scen_t;

    typedef struct {
        logic       i_ack, d_ack, resume;
        logic [3:0] st;
        logic       pcwre, irwre, regwre, mrd, mwr, dbsrc, halt, exc;
        logic [1:0] pcsrc, cause;
    } cyc_t;

    logic CLK, RST;
    logic [5:0] OP, func;
    logic zero, sign, overflow, i_ack, d_ack, resume;
    logic PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel, mRD, mWR;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc, exc_cause;
    logic [3:0] state;
    logic HALT, exc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;
    logic noise;
    logic [1:0] model_cause;
    cyc_t tr[$];
    scen_t tbl[20];
    logic [11:0] ilist[18];

    mc_ctrl_fsm #(.TMO_W(4), .OVF_TRAP(1'b1), .HALT_RESUME(1'b1)) dut (
        .CLK(CLK), .RST(RST), .OP(OP), .func(func), .zero(zero), .sign(sign),
        .overflow(overflow), .i_ack(i_ack), .d_ack(d_ack), .resume(resume),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR),
        .ALUOp(ALUOp), .RegDst(RegDst), .PCSrc(PCSrc), .state(state), .HALT(HALT),
        .exc(exc), .exc_cause(exc_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference decode table: {ALUSrcA, ALUSrcB, ExtSel, ALUOp[2:0], RegDst[1:0]}
    function automatic logic [7:0] exp_dec(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                if (fn == F_SLL)                     return 8'b100_010_01;
                if (fn == F_SUB || fn == F_SUBU)     return 8'b000_001_01;
                if (fn == F_AND)                     return 8'b000_100_01;
                if (fn == F_OR)                      return 8'b000_011_01;
                if (fn == F_SLT)                     return 8'b000_101_01;
                return 8'b000_000_01;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW:          return 8'b011_000_00;
            OP_SLTI:                                  return 8'b011_101_00;
            OP_ANDI:                                  return 8'b010_100_00;
            OP_ORI:                                   return 8'b010_011_00;
            OP_BEQ, OP_BNE, OP_BLTZ:                  return 8'b001_001_00;
            default:                                  return 8'b000_000_00;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_R && (fn == F_ADD || fn == F_SUB)) return C_AS;
        if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ) return C_BR;
        if (op == OP_LW)   return C_LW;
        if (op == OP_SW)   return C_SW;
        if (op == OP_J)    return C_J;
        if (op == OP_HALT) return C_HLT;
        return C_ALU;
    endfunction

    function automatic scen_t mks(input logic [5:0] op, input logic [5:0] fn, input int iw,
                                  input int dw, input int hw, input logic z, input logic s,
                                  input logic o);
        scen_t r;
        r.op = op; r.fn = fn; r.i_wait = iw; r.d_wait = dw; r.h_wait = hw;
        r.z = z; r.s = s; r.ovf = o;
        return r;
    endfunction

    // One expected cycle with all strobes idle; irrelevant handshakes get noise.
    function automatic cyc_t mk(input logic [3:0] st);
        cyc_t c;
        c.st = st;
        c.i_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c.d_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c.resume = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c.pcwre = 0; c.irwre = 0; c.regwre = 0; c.mrd = 0; c.mwr = 0;
        c.dbsrc = 0; c.halt = 0; c.exc = 0; c.pcsrc = 2'b00; c.cause = model_cause;
        return c;
    endfunction

    task automatic push_exc(input logic [1:0] cause);
        cyc_t c;
        model_cause = cause;
        c = mk(ST_EXC);
        c.exc = 1; c.pcwre = 1; c.pcsrc = 2'b10;
        tr.push_back(c);
    endtask

    // Expected cycle-by-cycle life of one instruction, from fetch to return to IF.
    task automatic build(input scen_t s);
        cyc_t c;
        int cls;
        cls = classify(s.op, s.fn);
        for (int k = 0; k < TMO && k < s.i_wait; k++) begin
            c = mk(ST_IF); c.i_ack = 0; tr.push_back(c);
        end
        if (s.i_wait >= TMO) begin
            push_exc(2'b10);
            return;
        end
        c = mk(ST_IF); c.i_ack = 1; c.irwre = 1; tr.push_back(c);
        c = mk(ST_ID);
        if (cls == C_J) begin
            c.pcwre = 1; c.pcsrc = 2'b11; tr.push_back(c);
            return;
        end
        tr.push_back(c);
        case (cls)
            C_HLT: begin
                for (int k = 0; k < s.h_wait; k++) begin
                    c = mk(ST_HLT); c.resume = 0; c.halt = 1; tr.push_back(c);
                end
                c = mk(ST_HLT); c.resume = 1; c.halt = 1; c.pcwre = 1; tr.push_back(c);
            end
            C_BR: begin
                c = mk(ST_EXEB); c.pcwre = 1;
                if ((s.op == OP_BEQ && s.z) || (s.op == OP_BNE && !s.z) || (s.op == OP_BLTZ && s.s))
                    c.pcsrc = 2'b01;
                tr.push_back(c);
            end
            C_LW, C_SW: begin
                c = mk(ST_EXELS); tr.push_back(c);
                for (int k = 0; k < TMO && k < s.d_wait; k++) begin
                    c = mk(ST_MEM); c.d_ack = 0; c.mrd = (cls == C_LW); c.mwr = (cls == C_SW);
                    tr.push_back(c);
                end
                if (s.d_wait >= TMO) begin
                    push_exc(2'b11);
                    return;
                end
                c = mk(ST_MEM); c.d_ack = 1; c.mrd = (cls == C_LW); c.mwr = (cls == C_SW);
                c.pcwre = (cls == C_SW);
                tr.push_back(c);
                if (cls == C_LW) begin
                    c = mk(ST_WBM); c.regwre = 1; c.pcwre = 1; c.dbsrc = 1; tr.push_back(c);
                end
            end
            default: begin
                c = mk(ST_EXEA); tr.push_back(c);
                if (cls == C_AS && s.ovf) begin
                    push_exc(2'b01);
                end else begin
                    c = mk(ST_WBA); c.regwre = 1; c.pcwre = 1; tr.push_back(c);
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] got_ctl();
        return {state, PCWre, IRWre, RegWre, mRD, mWR, DBDataSrc, HALT, exc, PCSrc, exc_cause};
    endfunction

    function automatic logic [7:0] got_dec();
        return {ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst};
    endfunction

    task automatic apply(input scen_t s);
        OP = s.op; func = s.fn; zero = s.z; sign = s.s; overflow = s.ovf;
    endtask

    task automatic run_n(input int n);
        cyc_t c;
        logic [7:0] d;
        for (int i = 0; i < n && tr.size() > 0; i++) begin
            c = tr.pop_front();
            i_ack = c.i_ack; d_ack = c.d_ack; resume = c.resume;
            @(negedge CLK);
            cyc_no++;
            check($sformatf("ctl@%0d st=%0h", cyc_no, c.st), 32'(got_ctl()),
                  32'({c.st, c.pcwre, c.irwre, c.regwre, c.mrd, c.mwr, c.dbsrc, c.halt,
                       c.exc, c.pcsrc, c.cause}));
            d = exp_dec(OP, func);
            if (c.st == ST_IF || c.st == ST_HLT || c.st == ST_EXC) d = {2'b00, d[5], 5'b00000};
            check($sformatf("dec@%0d st=%0h", cyc_no, c.st), 32'(got_dec()), 32'(d));
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_scen(input scen_t s);
        apply(s);
        build(s);
        run_n(1000);
    endtask

    initial begin
        scen_t s;
        int r;
        noise = 0; model_cause = 2'b00;
        RST = 1; OP = OP_LW; func = 0; zero = 0; sign = 0; overflow = 0;
        i_ack = 0; d_ack = 0; resume = 0;

        tbl[0]  = mks(OP_R, F_ADDU, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mks(OP_LW, 0, 0, 3, 0, 0, 0, 0);
        tbl[2]  = mks(OP_R, F_ADD, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mks(OP_SW, 0, 0, 20, 0, 0, 0, 0);
        tbl[4]  = mks(OP_HALT, 0, 0, 0, 4, 0, 0, 0);
        tbl[5]  = mks(OP_BEQ, 0, 1, 0, 0, 1, 0, 0);
        tbl[6]  = mks(OP_BEQ, 0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mks(OP_BNE, 0, 2, 0, 0, 0, 0, 0);
        tbl[8]  = mks(OP_BLTZ, 0, 0, 0, 0, 1, 1, 0);
        tbl[9]  = mks(OP_J, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mks(OP_ORI, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mks(OP_R, F_SLL, 0, 0, 0, 0, 0, 0);
        tbl[12] = mks(OP_R, F_SUB, 0, 0, 0, 0, 0, 0);
        tbl[13] = mks(OP_R, F_ADDU, 0, 0, 0, 0, 0, 1);
        tbl[14] = mks(OP_R, F_ADDU, 15, 0, 0, 0, 0, 0);
        tbl[15] = mks(OP_ADDI, 0, 14, 0, 0, 0, 0, 0);
        tbl[16] = mks(OP_LW, 0, 0, 14, 0, 0, 0, 0);
        tbl[17] = mks(OP_UNDEF, 6'h15, 0, 0, 0, 0, 0, 1);
        tbl[18] = mks(OP_SW, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mks(OP_R, F_SLT, 0, 0, 0, 0, 0, 0);

        ilist = '{{OP_R, F_ADD}, {OP_R, F_ADDU}, {OP_R, F_SUB}, {OP_R, F_SUBU}, {OP_R, F_AND},
                  {OP_R, F_OR}, {OP_R, F_SLT}, {OP_R, F_SLL}, {OP_ADDI, 6'h00}, {OP_ANDI, 6'h11},
                  {OP_SLTI, 6'h07}, {OP_LW, 6'h00}, {OP_SW, 6'h00}, {OP_BEQ, 6'h00},
                  {OP_BNE, 6'h00}, {OP_BLTZ, 6'h00}, {OP_J, 6'h00}, {OP_HALT, 6'h00}};

        // Reset state: everything idle, ExtSel from decode (lw sign-extends).
        #12;
        check("rst_ctl", 32'(got_ctl()), 32'h0);
        check("rst_dec", 32'(got_dec()), 32'h20);
        i_ack = 1;
        #1;
        check("rst_irwre", 32'(IRWre), 32'h1);
        i_ack = 0;
        @(posedge CLK);
        #1;
        RST = 0;

        for (int i = 0; i < 20; i++) run_scen(tbl[i]);

        noise = 1;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 17);
            s.op = ilist[r][11:6]; s.fn = ilist[r][5:0];
            r = $urandom_range(0, 9);
            s.i_wait = (r < 6) ? $urandom_range(0, 2) : (r < 8) ? $urandom_range(3, 14)
                                                                : $urandom_range(13, 16);
            r = $urandom_range(0, 9);
            s.d_wait = (r < 6) ? $urandom_range(0, 2) : (r < 8) ? $urandom_range(3, 14)
                                                                : $urandom_range(13, 16);
            s.h_wait = $urandom_range(0, 5);
            s.z = 1'($urandom_range(0, 1));
            s.s = 1'($urandom_range(0, 1));
            s.ovf = 1'($urandom_range(0, 1));
            run_scen(s);
        end

        // Reset in the middle of a store: abort immediately, cause cleared.
        noise = 0;
        run_scen(mks(OP_SW, 0, 0, 20, 0, 0, 0, 0));
        s = mks(OP_SW, 0, 0, 20, 0, 0, 0, 0);
        apply(s);
        build(s);
        run_n(5);
        tr.delete();
        i_ack = 0; d_ack = 0; resume = 0;
        #2;
        check("pre_rst_mwr", 32'(mWR), 32'h1);
        check("pre_rst_cause", 32'(exc_cause), 32'h3);
        RST = 1;
        #1;
        check("mid_rst_state", 32'(state), 32'h0);
        check("mid_rst_mwr", 32'(mWR), 32'h0);
        check("mid_rst_cause", 32'(exc_cause), 32'h0);
        check("mid_rst_wr", 32'({PCWre, RegWre}), 32'h0);
        i_ack = 1;
        @(posedge CLK);
        #1;
        check("rst_hold_state", 32'(state), 32'h0);
        RST = 0;
        i_ack = 0;
        model_cause = 2'b00;
        run_scen(mks(OP_R, F_ADDU, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
